// File: rtl/seg7_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl_if
// Handshake and data bus between the display scan controller and the
// decimal-to-BCD converter (dec_to_4_digit).
//
// Signals (named from the controller's point of view):
//   o_conv_start  controller -> converter  one-cycle start pulse
//   o_conv_num    controller -> converter  16-bit operand, held until latch
//   i_conv_d1     converter -> controller  thousands digit
//   i_conv_d2     converter -> controller  hundreds digit
//   i_conv_d3     converter -> controller  tens digit
//   i_conv_d4     converter -> controller  units digit
//
// Modports: master = scan controller, slave = converter.
// -----------------------------------------------------------------------------
interface seg7_scan_ctrl_if;
    logic        o_conv_start;
    logic [15:0] o_conv_num;
    logic [3:0]  i_conv_d1;
    logic [3:0]  i_conv_d2;
    logic [3:0]  i_conv_d3;
    logic [3:0]  i_conv_d4;

    modport master (
        output o_conv_start,
        output o_conv_num,
        input  i_conv_d1,
        input  i_conv_d2,
        input  i_conv_d3,
        input  i_conv_d4
    );

    modport slave (
        input  o_conv_start,
        input  o_conv_num,
        output i_conv_d1,
        output i_conv_d2,
        output i_conv_d3,
        output i_conv_d4
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Periodically samples a binary count, runs it through an external
// decimal-to-BCD converter, latches the four resulting digits and scans them
// onto a shared BCD bus with active-low anode selects.
//
// Parameters:
//   UPDATE_DIV   clk cycles between conversion requests
//   SCAN_DIV     clk cycles each digit stays enabled
//   CONV_CYCLES  clk cycles from start pulse until converter digits are valid
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   i_num    binary value to display
//   conv     converter bus (master side): start, operand, four BCD digits
//   o_anode  active-low digit enables, bit3 = thousands, bit0 = units
//   o_digit  BCD value of the currently enabled digit
//   o_busy   conversion in progress (START, WAIT, LATCH)
//   o_ovf    last sampled i_num exceeded 9999
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are blanked
//                          (units digit always shown); when undefined all
//                          four digits are always enabled.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int UPDATE_DIV  = 120000,
    parameter int SCAN_DIV    = 12000,
    parameter int CONV_CYCLES = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       i_num,
    seg7_scan_ctrl_if.master  conv,
    output logic [3:0]        o_anode,
    output logic [3:0]        o_digit,
    output logic              o_busy,
    output logic              o_ovf
);

    localparam int UPD_W  = (UPDATE_DIV  > 1) ? $clog2(UPDATE_DIV)  : 1;
    localparam int SCAN_W = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
    localparam int WAIT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    function automatic logic [15:0] clamp_9999(input logic [15:0] n);
        return (n > 16'd9999) ? 16'd9999 : n;
    endfunction

    // Converter glitches or out-of-range codes must never reach the pins.
    function automatic logic [3:0] bcd_clean(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A slot is a leading zero when it and every more significant digit is 0.
    function automatic logic is_lead_zero(input logic [3:0][3:0] d,
                                          input logic [1:0]      idx);
        logic z;
        case (idx)
            2'd3:    z = (d[3] == 4'd0);
            2'd2:    z = (d[3] == 4'd0) && (d[2] == 4'd0);
            2'd1:    z = (d[3] == 4'd0) && (d[2] == 4'd0) && (d[1] == 4'd0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction
`endif

    logic [UPD_W-1:0]  upd_cnt_q,  upd_cnt_d;
    logic              tick;
    logic [1:0]        state_q,    state_d;
    logic              pend_q,     pend_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]       num_q,      num_d;
    logic              ovf_q,      ovf_d;
    // Index 3 = thousands ... index 0 = units, matching the scan index.
    logic [3:0][3:0]   dig_q,      dig_d;
    logic              valid_q,    valid_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        idx_q,      idx_d;
    logic [3:0]        anode_q,    anode_d;
    logic [3:0]        digit_q,    digit_d;

    // Update divider: tick on the last count, i.e. the cycle the counter wraps.
    always_comb begin
        tick      = (upd_cnt_q == UPD_W'(UPDATE_DIV - 1));
        upd_cnt_d = tick ? '0 : upd_cnt_q + 1'b1;
    end

    // Conversion sequencer. Operand and overflow are captured on the
    // IDLE->START transition so they are already valid while start is high.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        wait_cnt_d = wait_cnt_q;
        num_d      = num_q;
        ovf_d      = ovf_q;
        dig_d      = dig_q;
        valid_d    = valid_q;

        // Ticks arriving while busy (including the LATCH cycle) collapse into
        // one pending request serviced from the following IDLE cycle.
        if (tick && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick || pend_q) begin
                    state_d = ST_START;
                    pend_d  = 1'b0;
                    num_d   = clamp_9999(i_num);
                    ovf_d   = (i_num > 16'd9999);
                end
            end
            ST_START: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_W'(CONV_CYCLES - 1)) begin
                    state_d = ST_LATCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                dig_d[3] = bcd_clean(conv.i_conv_d1);
                dig_d[2] = bcd_clean(conv.i_conv_d2);
                dig_d[1] = bcd_clean(conv.i_conv_d3);
                dig_d[0] = bcd_clean(conv.i_conv_d4);
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scan: anode and digit are both computed from next-state values so they
    // change together on one edge and a fresh latch shows without a glitch.
    always_comb begin
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q - 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
            idx_d      = idx_q;
        end

        anode_d = 4'b1111;
        if (valid_d) begin
            anode_d = ~(4'b0001 << idx_d);
`ifdef LEADING_ZERO_BLANK_EN
            if (is_lead_zero(dig_d, idx_d)) begin
                anode_d = 4'b1111;
            end
`endif
        end
        digit_d = dig_d[idx_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            wait_cnt_q <= '0;
            num_q      <= '0;
            ovf_q      <= 1'b0;
            dig_q      <= '0;
            valid_q    <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            anode_q    <= 4'b1111;
            digit_q    <= 4'd0;
        end else begin
            upd_cnt_q  <= upd_cnt_d;
            state_q    <= state_d;
            pend_q     <= pend_d;
            wait_cnt_q <= wait_cnt_d;
            num_q      <= num_d;
            ovf_q      <= ovf_d;
            dig_q      <= dig_d;
            valid_q    <= valid_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            anode_q    <= anode_d;
            digit_q    <= digit_d;
        end
    end

    assign conv.o_conv_start = (state_q == ST_START);
    assign conv.o_conv_num   = num_q;
    assign o_busy            = (state_q != ST_IDLE);
    assign o_ovf             = ovf_q;
    assign o_anode           = anode_q;
    assign o_digit           = digit_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl. Instance A uses UPDATE_DIV=64 for the
// display, clamping, operand-hold and reset scenarios; instance B uses
// UPDATE_DIV=16 so every conversion overlaps a tick. Each instance has a
// behavioral converter that drives 4'hF until CONV_CYCLES after start.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

    localparam int CONV = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_num = 16'd0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic [3:0] anode_a, digit_a, anode_b, digit_b;
    logic       busy_a, ovf_a, busy_b, ovf_b;

    seg7_scan_ctrl_if ca();
    seg7_scan_ctrl_if cb();

    seg7_scan_ctrl #(.UPDATE_DIV(64), .SCAN_DIV(4), .CONV_CYCLES(CONV)) dut_a (
        .clk(clk), .rst(rst), .i_num(i_num), .conv(ca),
        .o_anode(anode_a), .o_digit(digit_a), .o_busy(busy_a), .o_ovf(ovf_a)
    );

    seg7_scan_ctrl #(.UPDATE_DIV(16), .SCAN_DIV(4), .CONV_CYCLES(CONV)) dut_b (
        .clk(clk), .rst(rst), .i_num(i_num), .conv(cb),
        .o_anode(anode_b), .o_digit(digit_b), .o_busy(busy_b), .o_ovf(ovf_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] dec_digit(input logic [15:0] n, input int pos);
        int v;
        v = int'(n);
        for (int k = 0; k < pos; k++) v = v / 10;
        return 4'(v % 10);
    endfunction

    int cnt_a = 0;
    int cnt_b = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= 0;
            ca.i_conv_d1 <= 4'hF; ca.i_conv_d2 <= 4'hF;
            ca.i_conv_d3 <= 4'hF; ca.i_conv_d4 <= 4'hF;
        end else if (ca.o_conv_start) begin
            cnt_a <= CONV;
            ca.i_conv_d1 <= 4'hF; ca.i_conv_d2 <= 4'hF;
            ca.i_conv_d3 <= 4'hF; ca.i_conv_d4 <= 4'hF;
        end else if (cnt_a > 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 1) begin
                ca.i_conv_d1 <= dec_digit(ca.o_conv_num, 3);
                ca.i_conv_d2 <= dec_digit(ca.o_conv_num, 2);
                ca.i_conv_d3 <= dec_digit(ca.o_conv_num, 1);
                ca.i_conv_d4 <= dec_digit(ca.o_conv_num, 0);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_b <= 0;
            cb.i_conv_d1 <= 4'hF; cb.i_conv_d2 <= 4'hF;
            cb.i_conv_d3 <= 4'hF; cb.i_conv_d4 <= 4'hF;
        end else if (cb.o_conv_start) begin
            cnt_b <= CONV;
            cb.i_conv_d1 <= 4'hF; cb.i_conv_d2 <= 4'hF;
            cb.i_conv_d3 <= 4'hF; cb.i_conv_d4 <= 4'hF;
        end else if (cnt_b > 0) begin
            cnt_b <= cnt_b - 1;
            if (cnt_b == 1) begin
                cb.i_conv_d1 <= dec_digit(cb.o_conv_num, 3);
                cb.i_conv_d2 <= dec_digit(cb.o_conv_num, 2);
                cb.i_conv_d3 <= dec_digit(cb.o_conv_num, 1);
                cb.i_conv_d4 <= dec_digit(cb.o_conv_num, 0);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic get_start(input int sel);
        return (sel == 0) ? ca.o_conv_start : cb.o_conv_start;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    // Advance at least one sample, then wait for start high (bounded).
    task automatic wait_start(input int sel, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!get_start(sel) && n < 400);
        if (!get_start(sel)) check({tag, " start timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input int sel, input string tag);
        int n;
        n = 0;
        while (get_busy(sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (get_busy(sel)) check({tag, " idle timeout"}, 1, 0);
    endtask

    function automatic int anode_idx(input logic [3:0] a);
        case (a)
            4'b0111: return 3;
            4'b1011: return 2;
            4'b1101: return 1;
            4'b1110: return 0;
            default: return -1;
        endcase
    endfunction

    // Sample instance A's display for 16 cycles and compare against value.
    task automatic display_check(input string tag, input int value);
        logic [3:0] e [4];
        logic [3:0] allowed, seen;
        int         ok, idx;
        int         v;
        v = value;
        for (int k = 0; k < 4; k++) begin
            e[k] = 4'(v % 10);
            v = v / 10;
        end
        allowed = 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
        allowed[3] = (e[3] != 0);
        allowed[2] = (e[3] != 0) || (e[2] != 0);
        allowed[1] = (e[3] != 0) || (e[2] != 0) || (e[1] != 0);
`endif
        seen = 4'b0000;
        ok   = 0;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            idx = anode_idx(anode_a);
            if (anode_a == 4'b1111) begin
                if (allowed != 4'b1111) ok++;
            end else if (idx >= 0) begin
                seen[idx] = 1'b1;
                if (allowed[idx] && digit_a == e[idx]) ok++;
            end
        end
        check({tag, " good samples"}, ok, 16);
        check({tag, " slots lit"}, {28'd0, seen}, {28'd0, allowed});
    endtask

    function automatic logic [3:0] next_anode(input logic [3:0] a);
        case (a)
            4'b0111: return 4'b1011;
            4'b1011: return 4'b1101;
            4'b1101: return 4'b1110;
            default: return 4'b0111;
        endcase
    endfunction

    initial begin : stim
        int c0, t_start, n, bad, idle;
        logic [3:0] prev;

        // Reset state
        i_num = 16'd5432;
        repeat (3) @(negedge clk);
        check("rst anode", {28'd0, anode_a}, 32'hF);
        check("rst digit", {28'd0, digit_a}, 0);
        check("rst start", {31'd0, ca.o_conv_start}, 0);
        check("rst num", {16'd0, ca.o_conv_num}, 0);
        check("rst busy", {31'd0, busy_a}, 0);
        check("rst ovf", {31'd0, ovf_a}, 0);
        rst = 1'b0;
        c0 = cyc;

        // 1: 5432, latency, scan order, start period
        wait_start(0, "t1");
        t_start = cyc;
        check("t1 first start cycle", t_start - c0, 64);
        check("t1 num", {16'd0, ca.o_conv_num}, 5432);
        check("t1 ovf", {31'd0, ovf_a}, 0);
        check("t1 blank before latch", {28'd0, anode_a}, 32'hF);
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) check("t1 start width", {31'd0, ca.o_conv_start}, 0);
            if (!busy_a) break;
            n++;
        end
        check("t1 busy cycles", n, CONV + 2);
        bad  = 0;
        prev = anode_a;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            if (anode_a != prev && anode_a != next_anode(prev)) bad++;
            prev = anode_a;
        end
        check("t1 scan order", bad, 0);
        display_check("t1 5432", 5432);
        wait_start(0, "t1b");
        check("t1 start period", cyc - t_start, 64);

        // 2: overflow clamp, then back in range
        i_num = 16'd12345;
        wait_idle(0, "t2");
        wait_start(0, "t2");
        check("t2 num clamp", {16'd0, ca.o_conv_num}, 9999);
        check("t2 ovf", {31'd0, ovf_a}, 1);
        @(negedge clk);
        wait_idle(0, "t2");
        display_check("t2 9999", 9999);
        i_num = 16'd7;
        wait_start(0, "t2b");
        check("t2 ovf clear", {31'd0, ovf_a}, 0);
        check("t2 num 7", {16'd0, ca.o_conv_num}, 7);
        @(negedge clk);
        wait_idle(0, "t2b");
        display_check("t2 7", 7);

        // 3: operand held while i_num changes during WAIT
        i_num = 16'd1000;
        wait_start(0, "t3");
        check("t3 num", {16'd0, ca.o_conv_num}, 1000);
        repeat (5) @(negedge clk);
        i_num = 16'd2000;
        repeat (10) @(negedge clk);
        check("t3 num held", {16'd0, ca.o_conv_num}, 1000);
        wait_idle(0, "t3");
        display_check("t3 1000", 1000);
        wait_start(0, "t3b");
        check("t3 next num", {16'd0, ca.o_conv_num}, 2000);

        // 5: asynchronous reset mid-WAIT, clean restart
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5 anode", {28'd0, anode_a}, 32'hF);
        check("t5 busy", {31'd0, busy_a}, 0);
        check("t5 num", {16'd0, ca.o_conv_num}, 0);
        check("t5 digit", {28'd0, digit_a}, 0);
        check("t5 start", {31'd0, ca.o_conv_start}, 0);
        @(negedge clk);
        rst = 1'b0;
        c0  = cyc;
        bad = 0;
        n   = 0;
        while (!ca.o_conv_start && n < 400) begin
            @(negedge clk);
            n++;
            if (anode_a != 4'b1111) bad++;
        end
        check("t5 blank until latch", bad, 0);
        check("t5 restart cycle", cyc - c0, 64);
        @(negedge clk);
        wait_idle(0, "t5");
        display_check("t5 2000", 2000);

        // 4: fast ticks on instance B, back-to-back conversions
        wait_start(1, "t4");
        for (int r = 0; r < 4; r++) begin
            t_start = cyc;
            idle    = 0;
            n       = 0;
            do begin
                @(negedge clk);
                n++;
                if (!busy_b) idle++;
            end while (!cb.o_conv_start && n < 200);
            check($sformatf("t4 period %0d", r), cyc - t_start, CONV + 3);
            check($sformatf("t4 idle %0d", r), idle, 1);
        end

        // 6: leading-zero handling (blanked or all lit depending on build)
        i_num = 16'd0;
        wait_idle(0, "t6");
        wait_start(0, "t6");
        @(negedge clk);
        wait_idle(0, "t6");
        display_check("t6 0", 0);
        i_num = 16'd305;
        wait_start(0, "t6b");
        @(negedge clk);
        wait_idle(0, "t6b");
        display_check("t6 305", 305);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
